garegga_gfx_arb: RTL



---
 rtl/garegga_gfx_pkg.sv | 15 +
 rtl/garegga_gfx_arb_if.sv | 26 ++
 rtl/garegga_rr_pick.sv | 26 ++
 rtl/garegga_gfx_arb.sv | 111 +++++++++++
 4 files changed

// File: rtl/garegga_gfx_pkg.sv
// Shared types for the Garegga graphics ROM arbiter: FSM states and requester indices.
package garegga_gfx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   localparam int REQ_OBJ  = 0;
   localparam int REQ_SCR0 = 1;
   localparam int REQ_SCR1 = 2;
   localparam int REQ_SCR2 = 3;

endpackage

// File: rtl/garegga_gfx_arb_if.sv
// Requester-side and ROM-side handshake of the graphics ROM arbiter.
interface garegga_gfx_arb_if #(
   parameter int NREQ = 4,
   parameter int AW   = 22,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    REQ_CS;
   logic [NREQ*AW-1:0] REQ_ADDR;
   logic [NREQ-1:0]    REQ_OK;
   logic [DW-1:0]      REQ_DOUT;
   logic               ROM_CS;
   logic [AW-1:0]      ROM_ADDR;
   logic               ROM_OK;
   logic [DW-1:0]      ROM_DOUT;

   // master: the arbiter, which owns the ROM slot and answers the requesters
   modport master (
      input  REQ_CS, REQ_ADDR, ROM_OK, ROM_DOUT,
      output REQ_OK, REQ_DOUT, ROM_CS, ROM_ADDR
   );

   modport slave (
      output REQ_CS, REQ_ADDR, ROM_OK, ROM_DOUT,
      input  REQ_OK, REQ_DOUT, ROM_CS, ROM_ADDR
   );
endinterface

// File: rtl/garegga_rr_pick.sv
// Combinational round-robin selector: first set request scanning from last+1 upward, modulo NREQ.
module garegga_rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      last,
   output logic [1:0]      sel,
   output logic            any
);

   logic [1:0] w_idx;

   always_comb begin
      sel   = last;
      any   = 1'b0;
      w_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = 2'((int'(last) + k) % NREQ);
         if (!any && req[w_idx]) begin
            any = 1'b1;
            sel = w_idx;
         end
      end
   end

endmodule

// File: rtl/garegga_gfx_arb.sv
// Round-robin arbiter sharing one graphics ROM read port among OBJ and SCR0..SCR2 tile fetchers.
module garegga_gfx_arb
   import garegga_gfx_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int AW      = 22,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic              CLK,
   input  logic              RESET_N,
   garegga_gfx_arb_if.master bus,
   output logic [1:0]        GRANT,
   output logic              BUSY,
   output logic              TIMEOUT_ERR
);

   arb_state_t      r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_first;
   logic [NREQ-1:0] r_req_ok;
   logic [DW-1:0]   r_req_dout;
   logic            r_rom_cs;
   logic [AW-1:0]   r_rom_addr;
   logic [1:0]      r_grant;
   logic            r_busy;
   logic            r_terr;

   logic [1:0]      w_sel;
   logic            w_any;
   logic [AW-1:0]   w_sel_addr;
   logic            w_granted_cs;
   logic [CW-1:0]   w_cnt_nxt;

   garegga_rr_pick #(.NREQ(NREQ)) u_pick (
      .req  (bus.REQ_CS),
      .last (r_grant),
      .sel  (w_sel),
      .any  (w_any)
   );

   assign w_sel_addr   = bus.REQ_ADDR[int'(w_sel)*AW +: AW];
   assign w_granted_cs = bus.REQ_CS[r_grant];
   assign w_cnt_nxt    = r_cnt + 1'b1;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_first    <= 1'b0;
         r_req_ok   <= '0;
         r_req_dout <= '0;
         r_rom_cs   <= 1'b0;
         r_rom_addr <= '0;
         r_grant    <= 2'(NREQ-1);
         r_busy     <= 1'b0;
         r_terr     <= 1'b0;
      end else begin
         r_req_ok <= '0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grant    <= w_sel;
                  r_rom_addr <= w_sel_addr;
                  r_rom_cs   <= 1'b1;
                  r_cnt      <= '0;
                  r_first    <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               // ROM_OK in the first WAIT cycle may still belong to the previous address
               r_first <= 1'b0;
               if (!w_granted_cs) begin
                  r_rom_cs <= 1'b0;
                  r_state  <= DONE;
               end else if (!r_first && bus.ROM_OK) begin
                  r_req_dout        <= bus.ROM_DOUT;
                  r_req_ok[r_grant] <= 1'b1;
                  r_rom_cs          <= 1'b0;
                  r_state           <= DONE;
               end else if (w_cnt_nxt == CW'(TIMEOUT)) begin
                  r_req_dout        <= '0;
                  r_req_ok[r_grant] <= 1'b1;
                  r_terr            <= 1'b1;
                  r_rom_cs          <= 1'b0;
                  r_state           <= DONE;
               end else if (r_cnt != '1) begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.REQ_OK   = r_req_ok;
   assign bus.REQ_DOUT = r_req_dout;
   assign bus.ROM_CS   = r_rom_cs;
   assign bus.ROM_ADDR = r_rom_addr;
   assign GRANT        = r_grant;
   assign BUSY         = r_busy;
   assign TIMEOUT_ERR  = r_terr;

endmodule
